reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 64 ++++++
 tb/tb_reg_bank.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: 32-entry register file with two combinational read ports and
// one synchronous write port. Register 0 is hardwired to zero and register
// 29 (stack pointer) resets to SP_INIT; every other register resets to zero.
module reg_bank #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(227)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [4:0]        readReg1,
    input  logic [4:0]        readReg2,
    input  logic [31:0]       writeReg,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);

    localparam int NUM_REGS = 32;
    localparam int SP_IDX   = 29;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [4:0]        wr_idx;

    // The destination comes straight off the reg-dst mux, so only the low
    // five bits carry an index; the upper field is deliberately ignored.
    assign wr_idx = writeReg[4:0];

    logic unused_wr_hi;
    assign unused_wr_hi = ^writeReg[31:5];

    // Next-state: apply the single write, never letting index 0 change.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (regWrite && (wr_idx != 5'd0)) begin
            regs_d[wr_idx] = writeData;
        end
        regs_d[0] = '0;
    end

    // State update; reset wins over a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads come from stored state only: no write-to-read bypass, so a
    // same-cycle write shows up after the edge.
    always_comb begin
        readData1 = (readReg1 == 5'd0) ? '0 : regs_q[readReg1];
        readData2 = (readReg2 == 5'd0) ? '0 : regs_q[readReg2];
    end

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: the stimulus process pushes hand-computed
// expected read values; a monitor pops and compares them on the falling edge.
module tb_reg_bank;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          regWrite = 1'b0;
    logic [4:0]    readReg1 = '0;
    logic [4:0]    readReg2 = '0;
    logic [31:0]   writeReg = '0;
    logic [DW-1:0] writeData = '0;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;

    reg_bank #(.DATA_W(DW), .SP_INIT(32'd227)) dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    exp_t sb_q[$];
    logic chk_vld = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    // Monitor: one expected entry per valid sample slot.
    always @(negedge clk) begin
        if (chk_vld) begin
            n_total += 2;
            if (sb_q.size() == 0) begin
                $display("FAIL scoreboard_empty: got rd1=%h rd2=%h, want a queued entry", readData1, readData2);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (readData1 === e.e1) n_pass++;
                else $display("FAIL %s rd1: got %h want %h", e.nm, readData1, e.e1);
                if (readData2 === e.e2) n_pass++;
                else $display("FAIL %s rd2: got %h want %h", e.nm, readData2, e.e2);
            end
        end
    end

    // One cycle of stimulus; optionally queue the expected pre-edge reads.
    task automatic step(input logic rst_v, input logic we, input logic [31:0] wr,
                        input logic [DW-1:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                        input bit chk, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst_v;
        regWrite  = we;
        writeReg  = wr;
        writeData = wd;
        readReg1  = r1;
        readReg2  = r2;
        chk_vld   = chk;
        if (chk) begin
            e.nm = nm; e.e1 = e1; e.e2 = e2;
            sb_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [31:0] idx, input logic [DW-1:0] d);
        step(1'b0, 1'b1, idx, d, 5'd0, 5'd0, 1'b0, '0, '0, "");
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b,
                      input logic [DW-1:0] e1, input logic [DW-1:0] e2, input string nm);
        step(1'b0, 1'b0, 32'd0, '0, a, b, 1'b1, e1, e2, nm);
    endtask

    initial begin
        int wait_cyc;
        // Reset for one edge, then sweep every index on both ports.
        step(1'b1, 1'b0, 32'd0, '0, 5'd0, 5'd0, 1'b0, '0, '0, "");
        for (int i = 0; i < 32; i++) begin
            logic [DW-1:0] ev;
            ev = (i == 29) ? 32'd227 : 32'd0;
            rd(5'(i), 5'(i), ev, ev, $sformatf("reset_sweep_%0d", i));
        end

        // Basic write, both ports on the same register.
        wr(32'd8, 32'hDEADBEEF);
        rd(5'd8, 5'd8, 32'hDEADBEEF, 32'hDEADBEEF, "wr8_both_ports");

        // Writes to index 0 are dropped.
        wr(32'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd8, 32'd0, 32'hDEADBEEF, "wr0_discard");

        // regWrite low blocks the write; upper writeReg bits are ignored.
        step(1'b0, 1'b0, 32'd9, 32'h12345678, 5'd9, 5'd9, 1'b1, 32'd0, 32'd0, "we0_pre");
        rd(5'd9, 5'd29, 32'd0, 32'd227, "we0_no_write");
        step(1'b0, 1'b1, 32'h00000029, 32'h12345678, 5'd9, 5'd29, 1'b1, 32'd0, 32'd227, "hi_bits_pre");
        rd(5'd9, 5'd29, 32'h12345678, 32'd227, "hi_bits_write9");
        wr(32'hFFFFFFFF, 32'hCAFEF00D);
        rd(5'd31, 5'd9, 32'hCAFEF00D, 32'h12345678, "hi_bits_write31");

        // Same-cycle write and read: old value before the edge, new after.
        wr(32'd10, 32'h1);
        step(1'b0, 1'b1, 32'd10, 32'h2, 5'd10, 5'd8, 1'b1, 32'h1, 32'hDEADBEEF, "no_bypass_old");
        rd(5'd10, 5'd10, 32'h2, 32'h2, "no_bypass_new");

        // Reset beats a simultaneous write; state holds until the edge.
        wr(32'd29, 32'h55);
        rd(5'd29, 5'd3, 32'h55, 32'd0, "sp_written");
        step(1'b1, 1'b1, 32'd3, 32'hAA, 5'd29, 5'd8, 1'b1, 32'h55, 32'hDEADBEEF, "reset_pre_edge");
        rd(5'd29, 5'd3, 32'd227, 32'd0, "reset_wins");
        rd(5'd8, 5'd10, 32'd0, 32'd0, "reset_clears");

        step(1'b0, 1'b0, 32'd0, '0, 5'd0, 5'd0, 1'b0, '0, '0, "");
        wait_cyc = 0;
        while (sb_q.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
